frontend_pipe_regs: RTL and testbench

Front-end pipeline register bank for the 5-stage RV32I core. It holds the PC, IF/ID and ID/EX registers and applies the stall, flush and redirect controls produced by the hazard unit: stall_f, stall_d, flush_d, flush_e and pc_src_e. It sits between instruction memory, the decoder/register file and the execute stage. It also keeps saturating stall and flush performance counters for the debug CSR path.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_reg.sv | 20 ++
 rtl/frontend_pipe_regs.sv | 101 ++++++++++
 tb/tb_frontend_pipe_regs.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and the decode-to-execute bundle for the front-end pipeline registers.
package pipe_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          CTRL_W_DEF   = 12;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [XLEN_DEF-1:0]   rd1;
    logic [XLEN_DEF-1:0]   rd2;
    logic [XLEN_DEF-1:0]   imm;
    logic [XLEN_DEF-1:0]   pc;
    logic [XLEN_DEF-1:0]   pc_plus4;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  valid;
  } de_bundle_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset and synchronous clear both load CLR_VAL; clear beats enable.
module pipe_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= CLR_VAL;
    else if (clr) q <= CLR_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/frontend_pipe_regs.sv
// PC, IF/ID and ID/EX registers with hazard-unit stall/flush/redirect controls and
// saturating stall/flush performance counters.
module frontend_pipe_regs
  import pipe_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF,
  parameter int               CTRL_W   = CTRL_W_DEF,
  parameter int               CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_f,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              flush_e,
  input  logic              pc_src_e,
  input  logic [XLEN-1:0]   pc_target_e,
  input  logic [31:0]       instr_f,
  output logic [XLEN-1:0]   pc_f,
  output logic [31:0]       instr_d,
  output logic [XLEN-1:0]   pc_d,
  output logic [XLEN-1:0]   pc_plus4_d,
  output logic              valid_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic              valid_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int              FD_W    = 32 + 2*XLEN + 1;
  localparam int              DE_W    = CTRL_W + 5*XLEN + 15 + 1;
  localparam logic [FD_W-1:0] FD_CLR  = {NOP_INSTR, {(2*XLEN+1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] pc_plus4_f;
  logic [FD_W-1:0] fd_d, fd_q;
  logic [DE_W-1:0] de_d, de_q;

  assign pc_plus4_f = pc_f + XLEN'(4);

  // Redirect outranks stall so a taken branch is never lost behind a load-use hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc_f <= RESET_PC;
    else if (pc_src_e) pc_f <= pc_target_e;
    else if (!stall_f) pc_f <= pc_plus4_f;
  end

  assign fd_d = {instr_f, pc_f, pc_plus4_f, 1'b1};

  pipe_reg #(.WIDTH(FD_W), .CLR_VAL(FD_CLR)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .en    (~stall_d),
    .clr   (flush_d),
    .d     (fd_d),
    .q     (fd_q)
  );

  assign {instr_d, pc_d, pc_plus4_d, valid_d} = fd_q;

  assign de_d = {ctrl_d, rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d, valid_d};

  // No hold on ID/EX: a stalled decode always comes with flush_e from the hazard unit.
  pipe_reg #(.WIDTH(DE_W), .CLR_VAL('0)) u_id_ex (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (flush_e),
    .d     (de_d),
    .q     (de_q)
  );

  assign {ctrl_e, rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e, valid_e} = de_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((stall_f | stall_d) && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_d | flush_e) && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_frontend_pipe_regs.sv
// Randomized bench: two instances (default, and wrap/4-bit counters) checked against a rule-level model.
module tb_frontend_pipe_regs;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_f, stall_d, flush_d, flush_e, pc_src_e;
  logic [31:0] pc_target_e, instr_f, rd1_d, rd2_d, imm_d;
  logic [11:0] ctrl_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  logic [31:0] a_pc_f, a_instr_d, a_pc_d, a_pc4_d, a_rd1_e, a_rd2_e, a_imm_e, a_pc_e, a_pc4_e;
  logic [31:0] b_pc_f, b_instr_d, b_pc_d, b_pc4_d, b_rd1_e, b_rd2_e, b_imm_e, b_pc_e, b_pc4_e;
  logic        a_vd, a_ve, b_vd, b_ve;
  logic [11:0] a_ctrl_e, b_ctrl_e;
  logic [4:0]  a_rs1_e, a_rs2_e, a_rd_e, b_rs1_e, b_rs2_e, b_rd_e;
  logic [31:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  always #5 clk = ~clk;

  frontend_pipe_regs dut_a (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .instr_f(instr_f),
    .pc_f(a_pc_f), .instr_d(a_instr_d), .pc_d(a_pc_d), .pc_plus4_d(a_pc4_d), .valid_d(a_vd),
    .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_d(rd_d), .ctrl_e(a_ctrl_e), .rd1_e(a_rd1_e), .rd2_e(a_rd2_e), .imm_e(a_imm_e),
    .pc_e(a_pc_e), .pc_plus4_e(a_pc4_e), .rs1_e(a_rs1_e), .rs2_e(a_rs2_e), .rd_e(a_rd_e),
    .valid_e(a_ve), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  frontend_pipe_regs #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .instr_f(instr_f),
    .pc_f(b_pc_f), .instr_d(b_instr_d), .pc_d(b_pc_d), .pc_plus4_d(b_pc4_d), .valid_d(b_vd),
    .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_d(rd_d), .ctrl_e(b_ctrl_e), .rd1_e(b_rd1_e), .rd2_e(b_rd2_e), .imm_e(b_imm_e),
    .pc_e(b_pc_e), .pc_plus4_e(b_pc4_e), .rs1_e(b_rs1_e), .rs2_e(b_rs2_e), .rd_e(b_rd_e),
    .valid_e(b_ve), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  typedef struct {
    logic [31:0] pc, instr_d, pc_d, pc4_d;
    logic        vd;
    de_bundle_t  de;
    logic [31:0] sc, fc;
  } mdl_t;

  mdl_t        m [2];
  logic [31:0] rst_pc [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  logic [31:0] lim    [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t mreset(int k);
    mdl_t r;
    r.pc = rst_pc[k]; r.instr_d = NOP_INSTR; r.pc_d = '0; r.pc4_d = '0; r.vd = 1'b0;
    r.de = '0; r.sc = '0; r.fc = '0;
    return r;
  endfunction

  // One clock of the pipeline as the hazard rules describe it, from the old state s.
  function automatic mdl_t mstep(mdl_t s, int k);
    mdl_t n = s;
    if (pc_src_e)      n.pc = pc_target_e;
    else if (!stall_f) n.pc = s.pc + 32'd4;
    if (flush_d) begin
      n.instr_d = NOP_INSTR; n.pc_d = '0; n.pc4_d = '0; n.vd = 1'b0;
    end else if (!stall_d) begin
      n.instr_d = instr_f; n.pc_d = s.pc; n.pc4_d = s.pc + 32'd4; n.vd = 1'b1;
    end
    if (flush_e) n.de = '0;
    else begin
      n.de.ctrl = ctrl_d; n.de.rd1 = rd1_d; n.de.rd2 = rd2_d; n.de.imm = imm_d;
      n.de.pc = s.pc_d; n.de.pc_plus4 = s.pc4_d;
      n.de.rs1 = rs1_d; n.de.rs2 = rs2_d; n.de.rd = rd_d; n.de.valid = s.vd;
    end
    if ((stall_f || stall_d) && s.sc < lim[k]) n.sc = s.sc + 1;
    if ((flush_d || flush_e) && s.fc < lim[k]) n.fc = s.fc + 1;
    return n;
  endfunction

  task automatic cmp_inst(int k, logic [31:0] pc, logic [96:0] fd, logic [107:0] de1,
                          logic [79:0] de2, logic [31:0] sc, logic [31:0] fc);
    mdl_t e = m[k];
    chk($sformatf("pc_f[%0d]", k),  128'(pc), 128'(e.pc));
    chk($sformatf("if_id[%0d]", k), 128'(fd), 128'({e.instr_d, e.pc_d, e.pc4_d, e.vd}));
    chk($sformatf("id_ex_a[%0d]", k), 128'(de1), 128'({e.de.ctrl, e.de.rd1, e.de.rd2, e.de.imm}));
    chk($sformatf("id_ex_b[%0d]", k), 128'(de2),
        128'({e.de.pc, e.de.pc_plus4, e.de.rs1, e.de.rs2, e.de.rd, e.de.valid}));
    chk($sformatf("stall_cnt[%0d]", k), 128'(sc), 128'(e.sc));
    chk($sformatf("flush_cnt[%0d]", k), 128'(fc), 128'(e.fc));
  endtask

  task automatic check_all();
    cmp_inst(0, a_pc_f, {a_instr_d, a_pc_d, a_pc4_d, a_vd}, {a_ctrl_e, a_rd1_e, a_rd2_e, a_imm_e},
             {a_pc_e, a_pc4_e, a_rs1_e, a_rs2_e, a_rd_e, a_ve}, a_sc, a_fc);
    cmp_inst(1, b_pc_f, {b_instr_d, b_pc_d, b_pc4_d, b_vd}, {b_ctrl_e, b_rd1_e, b_rd2_e, b_imm_e},
             {b_pc_e, b_pc4_e, b_rs1_e, b_rs2_e, b_rd_e, b_ve}, {28'b0, b_sc}, {28'b0, b_fc});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) for (int k = 0; k < 2; k++) m[k] = mstep(m[k], k);
    #1 check_all();
  endtask

  task automatic ctl(logic sf, logic sd, logic fd, logic fe, logic ps);
    stall_f = sf; stall_d = sd; flush_d = fd; flush_e = fe; pc_src_e = ps;
  endtask

  task automatic rnd_data();
    instr_f = $urandom; ctrl_d = 12'($urandom); rd1_d = $urandom; rd2_d = $urandom;
    imm_d = $urandom; rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
    pc_target_e = $urandom & 32'hFFFF_FFFC;
  endtask

  // Assert reset mid-cycle (controls left as they are), check the immediate effect, release.
  task automatic do_reset();
    #3 reset = 1'b1;
    #1 for (int k = 0; k < 2; k++) m[k] = mreset(k);
    check_all();
    chk("rst_instr_d", 128'(a_instr_d), 128'(32'h0000_0013));
    chk("rst_valid", 128'({a_vd, a_ve}), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check_all();
  endtask

  initial begin
    ctl(0, 0, 0, 0, 0);
    rnd_data();
    for (int k = 0; k < 2; k++) m[k] = mreset(k);
    do_reset();

    // release sequence and PC wrap
    chk("rel_pc0", 128'(a_pc_f), 128'(32'h0));
    chk("wrap_pc0", 128'(b_pc_f), 128'(32'hFFFF_FFFC));
    rnd_data(); tick();
    chk("rel_pc1", 128'(a_pc_f), 128'(32'h4));
    chk("wrap_pc1", 128'(b_pc_f), 128'(32'h0));
    chk("wrap_pc4d", 128'(b_pc4_d), 128'(32'h0));
    rnd_data(); tick();
    chk("rel_pc2", 128'(a_pc_f), 128'(32'h8));
    rnd_data(); tick();
    chk("rel_pc3", 128'(a_pc_f), 128'(32'hC));

    // load-use bubble at pc_f=8
    do_reset();
    rnd_data(); tick();
    rnd_data(); tick();
    chk("lu_pre_pc", 128'(a_pc_f), 128'(32'h8));
    ctl(1, 1, 0, 1, 0); rnd_data(); tick();
    chk("lu_pc", 128'(a_pc_f), 128'(32'h8));
    chk("lu_pc_d", 128'(a_pc_d), 128'(32'h4));
    chk("lu_bubble", 128'({a_ctrl_e, a_ve}), 128'(0));
    chk("lu_cnts", 128'({a_sc, a_fc}), 128'({32'd1, 32'd1}));
    ctl(0, 0, 0, 0, 0); rnd_data(); tick();
    chk("lu_post_pc", 128'(a_pc_f), 128'(32'hC));

    // redirect at pc_f=0xC
    ctl(0, 0, 1, 1, 1); rnd_data(); pc_target_e = 32'h100; tick();
    chk("rd_pc", 128'(a_pc_f), 128'(32'h100));
    chk("rd_if_id", 128'({a_instr_d, a_vd}), 128'({32'h0000_0013, 1'b0}));
    chk("rd_ve", 128'(a_ve), 128'(0));
    chk("rd_fc", 128'(a_fc), 128'(32'd2));

    // priority: redirect beats stall_f, flush_d beats stall_d
    ctl(1, 1, 1, 0, 1); rnd_data(); pc_target_e = 32'h200; tick();
    chk("pri_pc", 128'(a_pc_f), 128'(32'h200));
    chk("pri_if_id", 128'({a_instr_d, a_pc_d, a_vd}), 128'({32'h0000_0013, 32'h0, 1'b0}));

    // saturation of the 4-bit counter
    ctl(1, 0, 0, 0, 0);
    repeat (20) begin rnd_data(); tick(); end
    chk("sat_sc", 128'(b_sc), 128'(4'd15));
    rnd_data(); tick();
    chk("sat_hold", 128'(b_sc), 128'(4'd15));

    // randomized traffic, including reset landing mid-stall/mid-flush
    repeat (400) begin
      ctl(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
          ($urandom % 5) == 0, ($urandom % 8) == 0);
      rnd_data();
      if (($urandom % 60) == 0) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
